// File: rtl/prog_loader_pkg.sv
// Shared parameters and types for the serial program loader.
package prog_loader_pkg;

    localparam int PC_WIDTH          = 8;
    localparam int INSTRUCTION_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface prog_loader_if
    import prog_loader_pkg::*;
#(
    parameter int PC_WIDTH          = prog_loader_pkg::PC_WIDTH,
    parameter int INSTRUCTION_WIDTH = prog_loader_pkg::INSTRUCTION_WIDTH
) ();

    logic [7:0]                   in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic                         mem_we;
    logic [PC_WIDTH-1:0]          mem_addr;
    logic [INSTRUCTION_WIDTH-1:0] mem_wdata;

    modport master (output in_data, output in_valid, input in_ready,
                    input mem_we, input mem_addr, input mem_wdata);

    modport slave  (input in_data, input in_valid, output in_ready,
                    output mem_we, output mem_addr, output mem_wdata);

endinterface

// File: rtl/prog_loader.sv
// Loads a counted, checksummed byte stream into instruction memory, MSB byte first.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int PC_WIDTH          = prog_loader_pkg::PC_WIDTH,
    parameter int INSTRUCTION_WIDTH = prog_loader_pkg::INSTRUCTION_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    prog_loader_if.slave  lif,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int B   = (INSTRUCTION_WIDTH + 7) / 8;
    localparam int SW  = B * 8;
    localparam int TW  = ((PC_WIDTH > 8) ? PC_WIDTH : 8) + 1;
    localparam int BCW = $clog2(B + 1);
    localparam logic [TW-1:0] ONE_TW = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] CAP    = ONE_TW << PC_WIDTH;

    state_t                       state_r, state_s;
    logic [TW-1:0]                total_r, total_s;
    logic [TW-1:0]                idx_r, idx_s;
    logic [TW-1:0]                count_ext_s;
    logic [BCW-1:0]               bcnt_r, bcnt_s;
    logic [SW-1:0]                shift_r, shift_s;
    logic [7:0]                   csum_r, csum_s;
    logic                         in_ready_r, in_ready_s;
    logic                         mem_we_r, mem_we_s;
    logic [PC_WIDTH-1:0]          mem_addr_r, mem_addr_s;
    logic [INSTRUCTION_WIDTH-1:0] mem_wdata_r, mem_wdata_s;
    logic                         busy_r, busy_s;
    logic                         done_r, done_s;
    logic                         err_r, err_s;
    logic                         accept_s;

    assign accept_s      = lif.in_valid & in_ready_r;
    assign lif.in_ready  = in_ready_r;
    assign lif.mem_we    = mem_we_r;
    assign lif.mem_addr  = mem_addr_r;
    assign lif.mem_wdata = mem_wdata_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;

    // Next-state and next-output decode; outputs are registered from these values.
    always_comb begin
        state_s     = state_r;
        total_s     = total_r;
        idx_s       = idx_r;
        bcnt_s      = bcnt_r;
        shift_s     = shift_r;
        csum_s      = csum_r;
        mem_we_s    = 1'b0;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        done_s      = done_r;
        err_s       = err_r;
        count_ext_s = {{(TW-8){1'b0}}, lif.in_data} + ONE_TW;

        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s = COUNT;
                    done_s  = 1'b0;
                    err_s   = 1'b0;
                    total_s = {TW{1'b0}};
                    idx_s   = {TW{1'b0}};
                    bcnt_s  = {BCW{1'b0}};
                    csum_s  = 8'h00;
                end else begin
                    state_s = state_r;
                end
            end
            COUNT: begin
                if (accept_s) begin
                    total_s = (count_ext_s > CAP) ? CAP : count_ext_s;
                    state_s = DATA;
                end else begin
                    state_s = COUNT;
                end
            end
            DATA: begin
                if (accept_s) begin
                    shift_s = (shift_r << 4'd8) | SW'(lif.in_data);
                    csum_s  = csum_add(csum_r, lif.in_data);
                    if (bcnt_r == BCW'(B - 1)) begin
                        // Output registers are loaded here so they are valid during WRITE.
                        bcnt_s      = {BCW{1'b0}};
                        state_s     = WRITE;
                        mem_we_s    = 1'b1;
                        mem_addr_s  = idx_r[PC_WIDTH-1:0];
                        mem_wdata_s = shift_s[INSTRUCTION_WIDTH-1:0];
                    end else begin
                        bcnt_s = bcnt_r + BCW'(1);
                    end
                end else begin
                    state_s = DATA;
                end
            end
            WRITE: begin
                idx_s = idx_r + ONE_TW;
                if ((idx_r + ONE_TW) == total_r) begin
                    state_s = CHECK;
                end else begin
                    state_s = DATA;
                end
            end
            CHECK: begin
                if (accept_s) begin
                    err_s   = (lif.in_data != csum_r);
                    done_s  = 1'b1;
                    state_s = DONE;
                end else begin
                    state_s = CHECK;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        in_ready_s = (state_s == COUNT) || (state_s == DATA) || (state_s == CHECK);
        busy_s     = (state_s == COUNT) || (state_s == DATA) ||
                     (state_s == WRITE) || (state_s == CHECK);
    end

    // State, datapath and output registers with immediate clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            total_r     <= {TW{1'b0}};
            idx_r       <= {TW{1'b0}};
            bcnt_r      <= {BCW{1'b0}};
            shift_r     <= {SW{1'b0}};
            csum_r      <= 8'h00;
            in_ready_r  <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {PC_WIDTH{1'b0}};
            mem_wdata_r <= {INSTRUCTION_WIDTH{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            total_r     <= total_s;
            idx_r       <= idx_s;
            bcnt_r      <= bcnt_s;
            shift_r     <= shift_s;
            csum_r      <= csum_s;
            in_ready_r  <= in_ready_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            err_r       <= err_s;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (PC_WIDTH=8, INSTRUCTION_WIDTH=16).
module tb_prog_loader;

    logic clk;
    logic rst_n;
    logic start;
    logic busy;
    logic done;
    logic err;

    int errors = 0;
    int checks = 0;

    logic [7:0]  wr_addr_log [0:1023];
    logic [15:0] wr_data_log [0:1023];
    int          wr_cnt = 0;
    int          bad_ready = 0;

    prog_loader_if #(.PC_WIDTH(8), .INSTRUCTION_WIDTH(16)) lif ();

    prog_loader #(.PC_WIDTH(8), .INSTRUCTION_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .lif   (lif.slave),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (lif.mem_we === 1'b1) begin
            wr_addr_log[wr_cnt] = lif.mem_addr;
            wr_data_log[wr_cnt] = lif.mem_wdata;
            wr_cnt = wr_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (lif.mem_we === 1'b1 && lif.in_ready !== 1'b0) bad_ready = bad_ready + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, output int waits);
        logic rdy;
        bit   ok;
        ok = 1'b0;
        waits = 0;
        @(negedge clk);
        lif.in_data  = b;
        lif.in_valid = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            rdy = lif.in_ready;
            waits = i;
            @(posedge clk);
            if (rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1;
        lif.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %02h not accepted, waited %0d cycles, required <= 50", b, waits);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        lif.in_valid = 1'b0;
        lif.in_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({lif.in_ready, lif.mem_we, lif.mem_addr, lif.mem_wdata, busy, done, err} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h wdata=%h busy=%b done=%b err=%b, required all 0",
                     lif.in_ready, lif.mem_we, lif.mem_addr, lif.mem_wdata, busy, done, err);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || lif.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b in_ready=%b, required 0 0", busy, lif.in_ready);
        end
    endtask

    task automatic run_small(input logic [7:0] csum_byte, input bit start_noise, output int base);
        int w;
        base = wr_cnt;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || lif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_enters_count: busy=%b done=%b in_ready=%b, required 1 0 1", busy, done, lif.in_ready);
        end
        send_byte(8'h01, w);
        send_byte(8'h12, w);
        if (start_noise) pulse_start();
        send_byte(8'h34, w);
        send_byte(8'hAB, w);
        checks++;
        if (w != 2) begin
            errors++;
            $display("FAIL hold_during_write: byte after word took %0d cycles, required 2", w);
        end
        if (start_noise) pulse_start();
        send_byte(8'hCD, w);
        if (start_noise) pulse_start();
        send_byte(csum_byte, w);
        @(negedge clk);
    endtask

    task automatic check_small(input string name, input int base, input logic exp_err);
        checks++;
        if (wr_cnt - base != 2) begin
            errors++;
            $display("FAIL %s_write_count: got %0d, required 2", name, wr_cnt - base);
        end else begin
            checks++;
            if (wr_addr_log[base] !== 8'h00 || wr_data_log[base] !== 16'h1234) begin
                errors++;
                $display("FAIL %s_word0: got %h@%h, required 1234@00", name, wr_data_log[base], wr_addr_log[base]);
            end
            checks++;
            if (wr_addr_log[base+1] !== 8'h01 || wr_data_log[base+1] !== 16'hABCD) begin
                errors++;
                $display("FAIL %s_word1: got %h@%h, required abcd@01", name, wr_data_log[base+1], wr_addr_log[base+1]);
            end
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || err !== exp_err || lif.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_final_flags: busy=%b done=%b err=%b in_ready=%b, required 0 1 %b 0",
                     name, busy, done, err, lif.in_ready, exp_err);
        end
        checks++;
        if (lif.mem_we !== 1'b0 || lif.mem_addr !== 8'h01 || lif.mem_wdata !== 16'hABCD) begin
            errors++;
            $display("FAIL %s_hold_outputs: we=%b addr=%h wdata=%h, required 0 01 abcd",
                     name, lif.mem_we, lif.mem_addr, lif.mem_wdata);
        end
    endtask

    // 12+34+AB+CD = 1BE, so the correct checksum is BE.
    task automatic test_basic();
        int base;
        run_small(8'hBE, 1'b0, base);
        check_small("basic", base, 1'b0);
    endtask

    task automatic test_bad_checksum();
        int base;
        run_small(8'hBF, 1'b0, base);
        check_small("bad_csum", base, 1'b1);
    endtask

    task automatic test_start_ignored();
        int base;
        run_small(8'hBE, 1'b1, base);
        check_small("start_ignored", base, 1'b0);
    endtask

    task automatic test_full_range();
        int base;
        int w;
        int bad;
        logic [7:0] sum;
        logic [7:0] lo;
        bad = 0;
        sum = 8'h00;
        base = wr_cnt;
        pulse_start();
        send_byte(8'hFF, w);
        for (int k = 0; k < 256; k++) begin
            lo = 8'h5A ^ 8'(k);
            send_byte(8'(k), w);
            send_byte(lo, w);
            sum = sum + 8'(k) + lo;
        end
        send_byte(sum, w);
        @(negedge clk);
        checks++;
        if (wr_cnt - base != 256) begin
            errors++;
            $display("FAIL full_write_count: got %0d, required 256", wr_cnt - base);
        end else begin
            for (int k = 0; k < 256; k++) begin
                if (wr_addr_log[base+k] !== 8'(k) || wr_data_log[base+k] !== {8'(k), 8'h5A ^ 8'(k)}) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL full_words: %0d words wrong (first %h@%h), required 0", bad,
                         wr_data_log[base], wr_addr_log[base]);
            end
        end
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_final_flags: done=%b err=%b busy=%b, required 1 0 0", done, err, busy);
        end
        checks++;
        if (bad_ready != 0) begin
            errors++;
            $display("FAIL ready_during_write: %0d cycles, required 0", bad_ready);
        end
    endtask

    task automatic test_reset_mid_session();
        int base;
        int w;
        base = wr_cnt;
        pulse_start();
        send_byte(8'h01, w);
        send_byte(8'h12, w);
        send_byte(8'h34, w);
        send_byte(8'hAB, w);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({lif.in_ready, lif.mem_we, lif.mem_addr, lif.mem_wdata, busy, done, err} !== 29'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got rdy=%b we=%b addr=%h wdata=%h busy=%b done=%b err=%b, required all 0",
                     lif.in_ready, lif.mem_we, lif.mem_addr, lif.mem_wdata, busy, done, err);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lif.in_data = 8'hCD;
        lif.in_valid = 1'b1;
        repeat (5) @(negedge clk);
        lif.in_valid = 1'b0;
        checks++;
        if (wr_cnt - base != 1) begin
            errors++;
            $display("FAIL mid_reset_writes: got %0d, required 1", wr_cnt - base);
        end else begin
            checks++;
            if (wr_addr_log[base] !== 8'h00 || wr_data_log[base] !== 16'h1234) begin
                errors++;
                $display("FAIL mid_reset_word0: got %h@%h, required 1234@00", wr_data_log[base], wr_addr_log[base]);
            end
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || lif.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle: busy=%b done=%b in_ready=%b, required 0 0 0", busy, done, lif.in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_checksum();
        test_start_ignored();
        test_full_range();
        test_reset_mid_session();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
